color_point_detector: RTL and testbench

Scans the decoded YCrCb pixel stream and classifies each active pixel against four programmable chroma windows, one per marker color. For every matching pixel it emits one (color, x, y) event. It asserts a level frame marker during vertical blanking, so the corner-recognition stage can accumulate per-color centroids over a frame and compute them between frames. It is the producer side of the interesting_* / frame_flag interface.

---
 rtl/color_point_detector_pkg.sv | 58 +++++
 rtl/chroma_window_match.sv | 19 +
 rtl/color_point_detector.sv | 169 ++++++++++++++++
 tb/tb_color_point_detector.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_point_detector_pkg.sv
// Shared types and constants for the color point detector: threshold
// register layout, coordinate widths and the disabled-window reset value.
package color_point_detector_pkg;

   localparam int unsigned NUM_COLORS = 4;
   localparam int unsigned COLOR_W    = 2;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned X_W        = 10;
   localparam int unsigned Y_W        = 9;
   localparam int unsigned HIT_W      = 8;
   localparam int unsigned CFG_ADDR_W = 4;

   localparam int unsigned    DEF_H_ACTIVE = 640;
   localparam int unsigned    DEF_V_ACTIVE = 480;
   localparam logic [PIX_W-1:0] DEF_Y_MIN  = 8'd32;
   localparam logic [HIT_W-1:0] DEF_MAX_HITS = 8'd255;

   // min above max makes a window unmatchable
   localparam logic [PIX_W-1:0] THR_MIN_RESET = 8'hFF;
   localparam logic [PIX_W-1:0] THR_MAX_RESET = 8'h00;

   typedef enum logic [1:0] {
      CR_MIN = 2'd0,
      CR_MAX = 2'd1,
      CB_MIN = 2'd2,
      CB_MAX = 2'd3
   } cfg_field_e;

   typedef struct packed {
      logic [PIX_W-1:0] cr_min;
      logic [PIX_W-1:0] cr_max;
      logic [PIX_W-1:0] cb_min;
      logic [PIX_W-1:0] cb_max;
   } window_t;

   localparam window_t WINDOW_DISABLED = '{
      cr_min: THR_MIN_RESET,
      cr_max: THR_MAX_RESET,
      cb_min: THR_MIN_RESET,
      cb_max: THR_MAX_RESET
   };

   // Returns the window with one threshold field replaced.
   function automatic window_t window_write(input window_t win,
                                            input cfg_field_e field,
                                            input logic [PIX_W-1:0] data);
      window_t w;
      w = win;
      case (field)
         CR_MIN: w.cr_min = data;
         CR_MAX: w.cr_max = data;
         CB_MIN: w.cb_min = data;
         CB_MAX: w.cb_max = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/chroma_window_match.sv
// Combinational test of one pixel against one color's chroma window and
// the luma floor; all bounds unsigned and inclusive.
module chroma_window_match
   import color_point_detector_pkg::*;
#(
   parameter logic [PIX_W-1:0] Y_MIN = DEF_Y_MIN
) (
   input  logic [PIX_W-1:0] y,
   input  logic [PIX_W-1:0] cr,
   input  logic [PIX_W-1:0] cb,
   input  window_t          win,
   output logic             match_c
);

   assign match_c = (y  >= Y_MIN)
                  & (cr >= win.cr_min) & (cr <= win.cr_max)
                  & (cb >= win.cb_min) & (cb <= win.cb_max);

endmodule

// File: rtl/color_point_detector.sv
// Classifies active pixels against four programmable chroma windows and emits
// one (color, x, y) event per match, plus a frame marker during blanking.
module color_point_detector
   import color_point_detector_pkg::*;
#(
   parameter int unsigned       H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned       V_ACTIVE = DEF_V_ACTIVE,
   parameter logic [PIX_W-1:0]  Y_MIN    = DEF_Y_MIN,
   parameter logic [HIT_W-1:0]  MAX_HITS = DEF_MAX_HITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  vid_valid,
   input  logic [PIX_W-1:0]      vid_y,
   input  logic [PIX_W-1:0]      vid_cr,
   input  logic [PIX_W-1:0]      vid_cb,
   input  logic                  vid_eol,
   input  logic                  vid_eof,
   input  logic                  cfg_we,
   input  logic [CFG_ADDR_W-1:0] cfg_addr,
   input  logic [PIX_W-1:0]      cfg_data,
   output logic [COLOR_W-1:0]    color,
   output logic [X_W-1:0]        interesting_x,
   output logic [Y_W-1:0]        interesting_y,
   output logic                  interesting_flag,
   output logic                  frame_flag
);

   localparam logic [X_W-1:0] X_SAT = '1;
   localparam logic [Y_W-1:0] Y_SAT = '1;
   localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

   logic [X_W-1:0] x_cnt;
   logic [Y_W-1:0] y_cnt;
   logic           synced;

   window_t [NUM_COLORS-1:0] cfg_win;
   window_t [NUM_COLORS-1:0] shadow_win;
   window_t [NUM_COLORS-1:0] active_win;
   logic                     shadow_load_c;
   logic [NUM_COLORS-1:0]    match_c;

   logic                  s1_valid;
   logic                  s1_eof;
   logic                  s1_synced;
   logic                  s1_in_active;
   logic [X_W-1:0]        s1_x;
   logic [Y_W-1:0]        s1_y;
   logic [NUM_COLORS-1:0] s1_match;

   logic [NUM_COLORS-1:0][HIT_W-1:0] hits;
   logic [COLOR_W-1:0]               win_color_c;
   logic                             any_match_c;
   logic                             fire_c;

   // Pixel position; saturating, frozen on gaps, cleared by end of frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_cnt  <= '0;
         y_cnt  <= '0;
         synced <= 1'b0;
      end else if (vid_valid) begin
         if (vid_eof) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            synced <= 1'b1;
         end else if (vid_eol) begin
            x_cnt <= '0;
            if (y_cnt != Y_SAT) y_cnt <= y_cnt + Y_W'(1);
         end else if (x_cnt != X_SAT) begin
            x_cnt <= x_cnt + X_W'(1);
         end
      end
   end

   // Frame-start pixel latches the shadow set; a same-cycle write lands after.
   assign shadow_load_c = vid_valid & (x_cnt == '0) & (y_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_win    <= {NUM_COLORS{WINDOW_DISABLED}};
         shadow_win <= {NUM_COLORS{WINDOW_DISABLED}};
      end else begin
         if (shadow_load_c) shadow_win <= cfg_win;
         if (cfg_we) begin
            cfg_win[cfg_addr[3:2]] <= window_write(cfg_win[cfg_addr[3:2]],
                                                   cfg_field_e'(cfg_addr[1:0]),
                                                   cfg_data);
         end
      end
   end

   // The frame-start pixel itself is classified with the newly latched set.
   assign active_win = shadow_load_c ? cfg_win : shadow_win;

   for (genvar c = 0; c < NUM_COLORS; c++) begin : g_match
      chroma_window_match #(
         .Y_MIN (Y_MIN)
      ) u_match (
         .y       (vid_y),
         .cr      (vid_cr),
         .cb      (vid_cb),
         .win     (active_win[c]),
         .match_c (match_c[c])
      );
   end

   // Stage 1: registered classification and position.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid     <= 1'b0;
         s1_eof       <= 1'b0;
         s1_synced    <= 1'b0;
         s1_in_active <= 1'b0;
         s1_x         <= '0;
         s1_y         <= '0;
         s1_match     <= '0;
      end else begin
         s1_valid     <= vid_valid;
         s1_eof       <= vid_valid & vid_eof;
         s1_synced    <= synced | (vid_valid & vid_eof);
         s1_in_active <= (x_cnt < H_LIM) & (y_cnt < V_LIM);
         s1_x         <= x_cnt;
         s1_y         <= y_cnt;
         s1_match     <= match_c;
      end
   end

   // Lowest matching index wins; capped colors are dropped.
   always_comb begin
      win_color_c = '0;
      any_match_c = 1'b0;
      for (int c = NUM_COLORS - 1; c >= 0; c--) begin
         if (s1_match[c]) begin
            win_color_c = COLOR_W'(c);
            any_match_c = 1'b1;
         end
      end
      fire_c = s1_valid & s1_in_active & s1_synced & any_match_c
             & (hits[win_color_c] < MAX_HITS);
   end

   // Stage 2: event outputs, frame marker and per-frame hit counts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         color            <= '0;
         interesting_x    <= '0;
         interesting_y    <= '0;
         interesting_flag <= 1'b0;
         frame_flag       <= 1'b0;
         hits             <= '0;
      end else begin
         interesting_flag <= fire_c;
         if (fire_c) begin
            color         <= win_color_c;
            interesting_x <= s1_x;
            interesting_y <= s1_y;
         end
         if (s1_valid) frame_flag <= s1_eof;
         if (s1_eof) begin
            hits <= '0;
         end else if (fire_c) begin
            hits[win_color_c] <= hits[win_color_c] + HIT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_color_point_detector.sv
// Self-checking bench: per-pixel behavioural model with a two-cycle result
// queue, compared against the DUT outputs every clock.
module tb_color_point_detector;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       vid_valid = 1'b0;
   logic [7:0] vid_y = '0, vid_cr = '0, vid_cb = '0;
   logic       vid_eol = 1'b0, vid_eof = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic [1:0] color;
   logic [9:0] interesting_x;
   logic [8:0] interesting_y;
   logic       interesting_flag;
   logic       frame_flag;

   always #5 clk = ~clk;

   color_point_detector dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .vid_valid        (vid_valid),
      .vid_y            (vid_y),
      .vid_cr           (vid_cr),
      .vid_cb           (vid_cb),
      .vid_eol          (vid_eol),
      .vid_eof          (vid_eof),
      .cfg_we           (cfg_we),
      .cfg_addr         (cfg_addr),
      .cfg_data         (cfg_data),
      .color            (color),
      .interesting_x    (interesting_x),
      .interesting_y    (interesting_y),
      .interesting_flag (interesting_flag),
      .frame_flag       (frame_flag)
   );

   typedef struct {
      bit valid;
      bit eof;
      bit fire;
      int col;
      int x;
      int y;
   } res_t;

   int checks = 0;
   int errors = 0;

   // model state
   int   m_x, m_y;
   bit   m_synced;
   int   m_hits[4];
   int   m_cfg[4][4];
   int   m_shadow[4][4];
   res_t pipe[$];
   bit   e_flag, e_ff;
   int   e_color, e_x, e_y;

   // observed DUT events
   int dut_ev[4];
   int last_col, last_x, last_y;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      res_t b;
      b = '{default: 0};
      m_x = 0; m_y = 0; m_synced = 0;
      for (int c = 0; c < 4; c++) begin
         m_hits[c] = 0;
         m_cfg[c] = '{255, 0, 255, 0};
         m_shadow[c] = '{255, 0, 255, 0};
      end
      pipe = {};
      pipe.push_back(b);
      pipe.push_back(b);
      e_flag = 0; e_ff = 0; e_color = 0; e_x = 0; e_y = 0;
   endfunction

   function automatic res_t model_in(bit v, int py, int pcr, int pcb, bit eol, bit eof,
                                     bit we, int addr, int data);
      res_t r;
      int   best;
      bit   sp;
      r = '{default: 0};
      if (v) begin
         if (m_x == 0 && m_y == 0) m_shadow = m_cfg;
         best = -1;
         for (int c = 3; c >= 0; c--)
            if (py >= 32 && pcr >= m_shadow[c][0] && pcr <= m_shadow[c][1]
                && pcb >= m_shadow[c][2] && pcb <= m_shadow[c][3])
               best = c;
         sp = m_synced || eof;
         if (eof) m_synced = 1;
         r.valid = 1; r.eof = eof; r.x = m_x; r.y = m_y; r.col = best;
         if (best >= 0 && m_x < 640 && m_y < 480 && sp)
            if (m_hits[best] < 255) begin
               r.fire = 1;
               m_hits[best]++;
            end
         if (eof) for (int c = 0; c < 4; c++) m_hits[c] = 0;
         if (eof) begin m_x = 0; m_y = 0; end
         else if (eol) begin m_x = 0; m_y = (m_y == 511) ? 511 : m_y + 1; end
         else m_x = (m_x == 1023) ? 1023 : m_x + 1;
      end
      if (we) m_cfg[addr / 4][addr % 4] = data;
      return r;
   endfunction

   // One clock: compare outputs against the model, then drive the next input.
   task automatic step(input bit v, input int py, input int pcr, input int pcb,
                       input bit eol, input bit eof, input bit we, input int addr,
                       input int data);
      res_t r;
      @(negedge clk);
      r = pipe.pop_front();
      if (r.valid) e_ff = r.eof;
      e_flag = r.fire;
      if (r.fire) begin e_color = r.col; e_x = r.x; e_y = r.y; end
      check("flag", int'(interesting_flag), int'(e_flag));
      check("frame_flag", int'(frame_flag), int'(e_ff));
      check("color", int'(color), e_color);
      check("x", int'(interesting_x), e_x);
      check("y", int'(interesting_y), e_y);
      if (interesting_flag) begin
         dut_ev[color]++;
         last_col = int'(color); last_x = int'(interesting_x); last_y = int'(interesting_y);
      end
      vid_valid = v; vid_y = 8'(py); vid_cr = 8'(pcr); vid_cb = 8'(pcb);
      vid_eol = eol; vid_eof = eof;
      cfg_we = we; cfg_addr = 4'(addr); cfg_data = 8'(data);
      pipe.push_back(model_in(v, py, pcr, pcb, eol, eof, we, addr, data));
   endtask

   task automatic pix(input int py, input int pcr, input int pcb, input bit eol, input bit eof);
      step(1'b1, py, pcr, pcb, eol, eof, 1'b0, 0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic wr(input int addr, input int data);
      step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, addr, data);
   endtask

   task automatic prog(input int c, input int crl, input int crh, input int cbl, input int cbh);
      wr(c * 4 + 0, crl); wr(c * 4 + 1, crh); wr(c * 4 + 2, cbl); wr(c * 4 + 3, cbh);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0; vid_valid = 1'b0; cfg_we = 1'b0; vid_eol = 1'b0; vid_eof = 1'b0;
      #1;
      check("rst_flag", int'(interesting_flag), 0);
      check("rst_frame_flag", int'(frame_flag), 0);
      check("rst_color", int'(color), 0);
      check("rst_x", int'(interesting_x), 0);
      check("rst_y", int'(interesting_y), 0);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic int total_ev();
      return dut_ev[0] + dut_ev[1] + dut_ev[2] + dut_ev[3];
   endfunction

   int base, nl, w;

   initial begin
      for (int c = 0; c < 4; c++) dut_ev[c] = 0;
      last_col = 0; last_x = 0; last_y = 0;
      model_reset();
      do_reset();

      // sync frame with disabled windows: no events, marker 2 clk after eof
      for (int l = 0; l < 4; l++)
         for (int p = 0; p < 10; p++) pix(100, 128, 128, p == 9, p == 9 && l == 3);
      idle(1);
      check("ff_before_rise", int'(frame_flag), 0);
      idle(1);
      check("ff_rise", int'(frame_flag), 1);
      check("sync_no_events", total_ev(), 0);

      // single color-2 pixel at (37,12)
      prog(2, 140, 160, 90, 110);
      base = dut_ev[2];
      for (int l = 0; l < 13; l++)
         for (int p = 0; p < 40; p++)
            if (l == 12 && p == 37) pix(80, 150, 100, 1'b0, 1'b0);
            else pix(100, 128, 128, p == 39, p == 39 && l == 12);
      idle(3);
      check("c2_count", dut_ev[2] - base, 1);
      check("c2_color", last_col, 2);
      check("c2_x", last_x, 37);
      check("c2_y", last_y, 12);

      // overlapping windows: priority and luma floor
      prog(1, 50, 70, 50, 70);
      prog(3, 60, 80, 60, 80);
      base = total_ev();
      pix(100, 128, 128, 0, 0);
      pix(80, 65, 65, 0, 0);
      pix(20, 65, 65, 0, 0);
      pix(100, 128, 128, 1, 1);
      idle(3);
      check("prio_count", total_ev() - base, 1);
      check("prio_color", last_col, 1);
      check("prio_x", last_x, 1);

      // per-frame cap, then restart next frame
      prog(0, 200, 220, 200, 220);
      base = dut_ev[0];
      for (int l = 0; l < 3; l++)
         for (int p = 0; p < 100; p++) pix(100, 210, 210, p == 99, 1'b0);
      pix(100, 128, 128, 1, 1);
      idle(3);
      check("cap_count", dut_ev[0] - base, 255);
      base = dut_ev[0];
      for (int p = 0; p < 10; p++) pix(100, 210, 210, 0, 0);
      pix(100, 128, 128, 1, 1);
      idle(3);
      check("cap_restart", dut_ev[0] - base, 10);

      // mid-frame rewrite takes effect only at the next frame
      base = dut_ev[0];
      for (int l = 0; l < 220; l++) begin
         if (l == 200) prog(0, 10, 20, 10, 20);
         pix(100, 210, 210, 0, 0);
         pix(100, 15, 15, 1, 0);
      end
      pix(100, 128, 128, 1, 1);
      idle(3);
      check("old_window_count", dut_ev[0] - base, 220);
      base = dut_ev[0];
      for (int l = 0; l < 5; l++) begin
         pix(100, 210, 210, 0, 0);
         pix(100, 15, 15, 1, l == 4);
      end
      idle(3);
      check("new_window_count", dut_ev[0] - base, 5);
      check("new_window_x", last_x, 1);

      // reset at y=100, resync with gaps
      for (int l = 0; l < 100; l++) begin
         pix(100, 210, 210, 0, 0);
         pix(100, 15, 15, 1, 0);
      end
      do_reset();
      prog(0, 10, 20, 10, 20);
      base = total_ev();
      for (int l = 0; l < 50; l++) begin
         pix(100, 15, 15, 0, 0);
         idle(3);
         pix(100, 15, 15, 1, 0);
      end
      pix(100, 128, 128, 1, 1);
      idle(3);
      check("presync_events", total_ev() - base, 0);
      base = total_ev();
      for (int l = 0; l < 5; l++) begin
         pix(100, 128, 128, 0, 0);
         idle(3);
         pix(100, 15, 15, 1, l == 4);
         idle(3);
      end
      idle(2);
      check("resync_count", total_ev() - base, 5);
      check("resync_x", last_x, 1);
      check("resync_y", last_y, 4);

      // active-area edges and counter saturation
      base = total_ev();
      for (int p = 0; p < 1030; p++)
         if ((p >= 630 && p < 650) || p >= 1024) pix(100, 15, 15, p == 1029, 0);
         else pix(100, 128, 128, p == 1029, 0);
      for (int l = 1; l < 525; l++)
         if ((l >= 470 && l < 490) || l >= 512) pix(100, 15, 15, 1, l == 524);
         else pix(100, 128, 128, 1, l == 524);
      idle(3);
      check("edge_count", total_ev() - base, 20);

      // randomized frames with gaps, config writes and one mid-frame reset
      prog(0, 100, 120, 100, 120);
      prog(1, 110, 140, 90, 130);
      prog(2, 130, 170, 130, 170);
      prog(3, 90, 170, 90, 170);
      for (int f = 0; f < 30; f++) begin
         nl = $urandom_range(1, 6);
         for (int l = 0; l < nl; l++) begin
            w = $urandom_range(1, 12);
            for (int p = 0; p < w; p++) begin
               while ($urandom_range(0, 3) == 0) begin
                  if ($urandom_range(0, 7) == 0) wr($urandom_range(0, 15), $urandom_range(90, 170));
                  else idle(1);
               end
               pix($urandom_range(0, 80), $urandom_range(90, 170), $urandom_range(90, 170),
                   p == w - 1, p == w - 1 && l == nl - 1);
            end
            if (f == 15 && l == 0 && nl > 1) begin
               do_reset();
               prog(0, 100, 120, 100, 120);
               prog(3, 90, 170, 90, 170);
            end
         end
         idle($urandom_range(0, 3));
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
